// File: rtl/gcd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : gcd_arbiter
//  Purpose  : Round-robin front end that shares one gcd core among NUM_REQ
//             requesters. It accepts one operand pair at a time, gives the
//             core a single-cycle start and waits for its valid pulse. The
//             result goes back to the granted requester on a valid/ready
//             response channel. A watchdog returns an error response if the
//             core never answers.
//  Revision : 1.0  initial release
// ============================================================================
module gcd_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int WIDTH   = 32,
    parameter int TIMEOUT = 1024
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    // requester side
    input  logic [NUM_REQ-1:0]       req_valid_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_a_i,
    input  logic [NUM_REQ*WIDTH-1:0] req_b_i,
    output logic [NUM_REQ-1:0]       req_ready_o,
    output logic [NUM_REQ-1:0]       rsp_valid_o,
    output logic [WIDTH-1:0]         rsp_result_o,
    output logic                     rsp_err_o,
    input  logic [NUM_REQ-1:0]       rsp_ready_i,
    // core side
    output logic                     gcd_start_o,
    output logic [WIDTH-1:0]         gcd_a_o,
    output logic [WIDTH-1:0]         gcd_b_o,
    input  logic                     gcd_busy_i,
    input  logic                     gcd_valid_i,
    input  logic [WIDTH-1:0]         gcd_result_i
);

    // ------------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------------
    // Requester id width; NUM_REQ >= 2 so this is at least one bit.
    localparam int c_id_w   = $clog2(NUM_REQ);
    // One extra bit so last_grant + offset (at most 2*NUM_REQ-1) never wraps.
    localparam int c_scan_w = c_id_w + 1;
    // Watchdog counter only has to reach TIMEOUT-1.
    localparam int c_cnt_w  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

    // After reset the "last served" requester is the highest one, so the
    // first search starts at requester 0.
    localparam logic [c_id_w-1:0]  c_last_init = c_id_w'(NUM_REQ - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_last  = c_cnt_w'(TIMEOUT - 1);
    localparam logic [c_cnt_w-1:0] c_cnt_one   = c_cnt_w'(1);
    localparam logic [c_scan_w-1:0] c_scan_num = c_scan_w'(NUM_REQ);

    // ------------------------------------------------------------------------
    // State encoding
    // ------------------------------------------------------------------------
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,   // arbitrate among pending requests
        ST_ISSUE = 2'd1,   // one-cycle start to the core
        ST_WAIT  = 2'd2,   // wait for core valid or watchdog expiry
        ST_RESP  = 2'd3    // hold the response until the owner accepts it
    } state_t;

    state_t                r_state;
    state_t                w_next_state;

    logic [c_id_w-1:0]     r_last_grant;   // requester served most recently
    logic [c_id_w-1:0]     r_id;           // owner of the operation in flight
    logic [WIDTH-1:0]      r_op_a;
    logic [WIDTH-1:0]      r_op_b;
    logic [WIDTH-1:0]      r_result;
    logic                  r_err;
    logic [c_cnt_w-1:0]    r_count;        // cycles spent in WAIT

    logic                  w_found;
    logic [c_id_w-1:0]     w_grant_id;
    logic [c_scan_w-1:0]   w_scan;
    logic [NUM_REQ-1:0]    w_grant_onehot;
    logic [NUM_REQ-1:0]    w_id_onehot;
    logic [WIDTH-1:0]      w_sel_a;
    logic [WIDTH-1:0]      w_sel_b;
    logic                  w_count_done;

    assign w_count_done = (r_count == c_cnt_last);

    // ------------------------------------------------------------------------
    // Round-robin search: first valid requester above last_grant, wrapping.
    // ------------------------------------------------------------------------
    always_comb begin
        w_found    = 1'b0;
        w_grant_id = '0;
        w_scan     = '0;
        for (int k = 1; k <= NUM_REQ; k++) begin
            w_scan = {1'b0, r_last_grant} + c_scan_w'(k);
            if (w_scan >= c_scan_num) begin
                w_scan = w_scan - c_scan_num;
            end
            if (!w_found && req_valid_i[w_scan[c_id_w-1:0]]) begin
                w_found    = 1'b1;
                w_grant_id = w_scan[c_id_w-1:0];
            end
        end
    end

    // Decode the candidate grant and the in-flight owner to one-hot vectors,
    // and pick the candidate's operand slices.
    always_comb begin
        w_grant_onehot = '0;
        w_id_onehot    = '0;
        w_sel_a        = '0;
        w_sel_b        = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (w_grant_id == c_id_w'(i)) begin
                w_grant_onehot[i] = 1'b1;
                w_sel_a           = req_a_i[i*WIDTH +: WIDTH];
                w_sel_b           = req_b_i[i*WIDTH +: WIDTH];
            end
            if (r_id == c_id_w'(i)) begin
                w_id_onehot[i] = 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // FSM next-state and handshake outputs.
    always_comb begin
        w_next_state = r_state;
        req_ready_o  = '0;
        rsp_valid_o  = '0;
        gcd_start_o  = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_found) begin
                    w_next_state = ST_ISSUE;
                    // The accept pulse is combinational; keep it quiet while
                    // reset is held so every output reads zero in reset.
                    if (!rst_i) begin
                        req_ready_o = w_grant_onehot;
                    end
                end
            end
            ST_ISSUE: begin
                gcd_start_o  = 1'b1;
                w_next_state = ST_WAIT;
            end
            ST_WAIT: begin
                if (gcd_valid_i || w_count_done) begin
                    w_next_state = ST_RESP;
                end
            end
            ST_RESP: begin
                rsp_valid_o = w_id_onehot;
                // Only the owner's ready bit can close the response.
                if (rsp_ready_i[r_id]) begin
                    w_next_state = ST_IDLE;
                end
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Datapath: capture operands on grant, run the watchdog, capture result.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_last_grant <= c_last_init;
            r_id         <= '0;
            r_op_a       <= '0;
            r_op_b       <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_count      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_found) begin
                        r_id   <= w_grant_id;
                        r_op_a <= w_sel_a;
                        r_op_b <= w_sel_b;
                    end
                end
                ST_ISSUE: begin
                    r_count <= '0;
                end
                ST_WAIT: begin
                    // A valid pulse on the expiry cycle still counts as a
                    // real result.
                    if (gcd_valid_i) begin
                        r_result <= gcd_result_i;
                        r_err    <= 1'b0;
                    end else if (w_count_done) begin
                        r_result <= '0;
                        r_err    <= 1'b1;
                    end else begin
                        r_count <= r_count + c_cnt_one;
                    end
                end
                ST_RESP: begin
                    if (rsp_ready_i[r_id]) begin
                        r_last_grant <= r_id;
                    end
                end
                default: begin
                    r_count <= '0;
                end
            endcase
        end
    end

    // Operands stay on the core bus from ISSUE through RESP; the response
    // payload is only presented while the response is valid.
    assign gcd_a_o      = r_op_a;
    assign gcd_b_o      = r_op_b;
    assign rsp_result_o = (r_state == ST_RESP) ? r_result : '0;
    assign rsp_err_o    = (r_state == ST_RESP) ? r_err    : 1'b0;

    // ------------------------------------------------------------------------
    // Protocol checks (simulation only)
    // ------------------------------------------------------------------------
`ifndef SYNTHESIS
    // The core must be idle whenever a new start is issued.
    a_core_idle_on_issue : assert property (
        @(posedge clk_i) disable iff (rst_i)
        (r_state == ST_ISSUE) |-> !gcd_busy_i
    );

    // Accept and response vectors never address more than one requester.
    a_ready_onehot : assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(req_ready_o)
    );

    a_rsp_onehot : assert property (
        @(posedge clk_i) disable iff (rst_i) $onehot0(rsp_valid_o)
    );
`endif

endmodule
`default_nettype wire

// File: tb/tb_gcd_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_gcd_arbiter
//  Purpose  : Directed self-checking bench for gcd_arbiter with a behavioural
//             gcd core that can be muted to exercise the watchdog.
//  Revision : 1.0  initial release
// ============================================================================
module tb_gcd_arbiter;

    localparam int N  = 4;
    localparam int W  = 32;
    localparam int TO = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [N-1:0]     req_valid;
    logic [N*W-1:0]   req_a;
    logic [N*W-1:0]   req_b;
    logic [N-1:0]     req_ready;
    logic [N-1:0]     rsp_valid;
    logic [W-1:0]     rsp_result;
    logic             rsp_err;
    logic [N-1:0]     rsp_ready;
    logic             gcd_start;
    logic [W-1:0]     gcd_a;
    logic [W-1:0]     gcd_b;
    logic             gcd_busy;
    logic             gcd_valid;
    logic [W-1:0]     gcd_result;

    // behavioural core state
    logic             core_valid;
    logic [W-1:0]     core_res;
    logic [W-1:0]     core_a;
    logic [W-1:0]     core_b;
    int               core_cnt;
    logic             core_mute;
    logic             inj_valid;

    int               n_checks = 0;
    int               n_fail   = 0;

    always #5 clk = ~clk;

    gcd_arbiter #(.NUM_REQ(N), .WIDTH(W), .TIMEOUT(TO)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .req_valid_i  (req_valid),
        .req_a_i      (req_a),
        .req_b_i      (req_b),
        .req_ready_o  (req_ready),
        .rsp_valid_o  (rsp_valid),
        .rsp_result_o (rsp_result),
        .rsp_err_o    (rsp_err),
        .rsp_ready_i  (rsp_ready),
        .gcd_start_o  (gcd_start),
        .gcd_a_o      (gcd_a),
        .gcd_b_o      (gcd_b),
        .gcd_busy_i   (gcd_busy),
        .gcd_valid_i  (gcd_valid),
        .gcd_result_i (gcd_result)
    );

    // Injected pulses model a stray/late core valid with a junk result.
    assign gcd_valid  = core_valid | inj_valid;
    assign gcd_result = inj_valid ? 32'hDEAD_BEEF : core_res;

    function automatic logic [W-1:0] gcd_fn(input logic [W-1:0] a, input logic [W-1:0] b);
        logic [W-1:0] x;
        logic [W-1:0] y;
        logic [W-1:0] t;
        x = a;
        y = b;
        while (y != 0) begin
            t = x % y;
            x = y;
            y = t;
        end
        return x;
    endfunction

    // Core: fixed 3-cycle latency after start, valid pulse unless muted.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            core_valid <= 1'b0;
            core_res   <= '0;
            core_a     <= '0;
            core_b     <= '0;
            core_cnt   <= 0;
            gcd_busy   <= 1'b0;
        end else begin
            core_valid <= 1'b0;
            if (core_cnt > 0) begin
                core_cnt <= core_cnt - 1;
                if (core_cnt == 1) begin
                    gcd_busy <= 1'b0;
                    if (!core_mute) begin
                        core_valid <= 1'b1;
                        core_res   <= gcd_fn(core_a, core_b);
                    end
                end
            end else if (gcd_start) begin
                core_a   <= gcd_a;
                core_b   <= gcd_b;
                gcd_busy <= 1'b1;
                core_cnt <= 3;
            end
        end
    end

    task automatic check_val(input string tag, input logic [W-1:0] got, input logic [W-1:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_ready();
        int n;
        n = 0;
        while (req_ready == '0 && n < 40) begin
            tick();
            n++;
        end
        check_val("ready_seen", W'(req_ready != '0), 1);
    endtask

    task automatic wait_rsp(output int n);
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            tick();
            n++;
        end
        check_val("rsp_seen", W'(rsp_valid != '0), 1);
    endtask

    task automatic set_req(input int id, input logic [W-1:0] a, input logic [W-1:0] b);
        req_a[id*W +: W] = a;
        req_b[id*W +: W] = b;
    endtask

    // One complete request/response for a single requester, rsp_ready all high.
    task automatic transact(input string tag, input int id, input logic [W-1:0] a,
                            input logic [W-1:0] b, input logic [W-1:0] res,
                            input logic err, input int lat);
        int n;
        set_req(id, a, b);
        req_valid[id] = 1'b1;
        #1;
        wait_ready();
        check_val({tag, "_ready"}, W'(req_ready), W'(1 << id));
        tick();
        req_valid[id] = 1'b0;
        check_val({tag, "_start"}, W'(gcd_start), 1);
        check_val({tag, "_ready_off"}, W'(req_ready), 0);
        check_val({tag, "_opa"}, gcd_a, a);
        check_val({tag, "_opb"}, gcd_b, b);
        tick();
        check_val({tag, "_start_off"}, W'(gcd_start), 0);
        wait_rsp(n);
        check_val({tag, "_lat"}, W'(n), W'(lat));
        check_val({tag, "_rsp_valid"}, W'(rsp_valid), W'(1 << id));
        check_val({tag, "_result"}, rsp_result, res);
        check_val({tag, "_err"}, W'(rsp_err), W'(err));
        tick();
        check_val({tag, "_rsp_done"}, W'(rsp_valid), 0);
    endtask

    // Stimulus
    initial begin
        int n;
        int id;
        int exp_res [4] = '{4, 7, 1, 25};

        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = '1;
        core_mute = 1'b0;
        inj_valid = 1'b0;

        // Reset values, with a request pending to show accept is suppressed.
        repeat (2) @(posedge clk);
        #1;
        req_valid = 4'b0001;
        #1;
        check_val("rst_req_ready", W'(req_ready), 0);
        check_val("rst_rsp_valid", W'(rsp_valid), 0);
        check_val("rst_result", rsp_result, 0);
        check_val("rst_err", W'(rsp_err), 0);
        check_val("rst_start", W'(gcd_start), 0);
        check_val("rst_gcd_a", gcd_a, 0);
        check_val("rst_gcd_b", gcd_b, 0);
        req_valid = '0;
        rst = 1'b0;
        tick();

        // Single request, gcd(48,18)=6
        transact("t1", 0, 48, 18, 6, 1'b0, 4);

        // Fresh reset, then all four requesters continuously valid
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        set_req(0, 12, 8);
        set_req(1, 35, 14);
        set_req(2, 17, 5);
        set_req(3, 100, 75);
        req_valid = 4'b1111;
        #1;
        for (int k = 0; k < 5; k++) begin
            id = k % 4;
            wait_ready();
            check_val("rr_grant", W'(req_ready), W'(1 << id));
            tick();
            if (k == 4) req_valid = '0;
            wait_rsp(n);
            check_val("rr_rsp_valid", W'(rsp_valid), W'(1 << id));
            check_val("rr_result", rsp_result, W'(exp_res[id]));
            check_val("rr_err", W'(rsp_err), 0);
            tick();
        end

        // Backpressure on requester 2 while requester 0 waits
        rsp_ready = 4'b1011;
        req_valid = 4'b0100;
        #1;
        wait_ready();
        check_val("bp_grant2", W'(req_ready), 4'b0100);
        tick();
        req_valid = 4'b0001;
        wait_rsp(n);
        check_val("bp_rsp_valid", W'(rsp_valid), 4'b0100);
        check_val("bp_result", rsp_result, 1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("bp_hold_valid", W'(rsp_valid), 4'b0100);
            check_val("bp_hold_result", rsp_result, 1);
            check_val("bp_hold_noready", W'(req_ready), 0);
        end
        rsp_ready = 4'b1111;
        tick();
        check_val("bp_grant0", W'(req_ready), 4'b0001);
        tick();
        req_valid = '0;
        wait_rsp(n);
        check_val("bp_rsp0_valid", W'(rsp_valid), 4'b0001);
        check_val("bp_rsp0_result", rsp_result, 4);
        tick();

        // Zero operands pass straight through
        transact("z1", 1, 0, 7, 7, 1'b0, 4);
        transact("z2", 1, 9, 0, 9, 1'b0, 4);

        // Watchdog with a silent core, then a late valid in IDLE
        core_mute = 1'b1;
        transact("to", 2, 21, 14, 0, 1'b1, 16);
        inj_valid = 1'b1;
        tick();
        inj_valid = 1'b0;
        check_val("late_rsp_valid", W'(rsp_valid), 0);
        check_val("late_start", W'(gcd_start), 0);
        tick();
        check_val("late_rsp_valid2", W'(rsp_valid), 0);
        check_val("late_err", W'(rsp_err), 0);
        core_mute = 1'b0;

        // Reset in the middle of WAIT
        set_req(3, 100, 75);
        req_valid = 4'b1000;
        #1;
        wait_ready();
        tick();
        req_valid = '0;
        tick();
        tick();
        rst = 1'b1;
        set_req(0, 48, 18);
        req_valid = 4'b1001;
        #1;
        check_val("mrst_rsp_valid", W'(rsp_valid), 0);
        check_val("mrst_result", rsp_result, 0);
        check_val("mrst_err", W'(rsp_err), 0);
        check_val("mrst_start", W'(gcd_start), 0);
        check_val("mrst_gcd_a", gcd_a, 0);
        check_val("mrst_req_ready", W'(req_ready), 0);
        tick();
        check_val("mrst_rsp_valid2", W'(rsp_valid), 0);
        rst = 1'b0;
        #1;
        check_val("mrst_grant0", W'(req_ready), 4'b0001);
        tick();
        req_valid = 4'b1000;
        wait_rsp(n);
        check_val("mrst_rsp0", W'(rsp_valid), 4'b0001);
        check_val("mrst_res0", rsp_result, 6);
        tick();
        check_val("mrst_grant3", W'(req_ready), 4'b1000);
        tick();
        req_valid = '0;
        wait_rsp(n);
        check_val("mrst_rsp3", W'(rsp_valid), 4'b1000);
        check_val("mrst_res3", rsp_result, 25);
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

    // Hard stop in case the stimulus itself stalls
    initial begin
        #200000;
        $display("FAIL watchdog: got=stalled want=finish");
        $fatal(1, "simulation time limit");
    end

endmodule
`default_nettype wire
